// File: rtl/bus_arbiter_if.sv
// Master-side bus bundle between the two requesting masters, the arbiter and the address decoder.
// The arbiter takes the slave modport; whatever drives the masters' requests takes the master modport.
interface bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_dout;
    logic              m1_req;
    logic              m1_wr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_dout;
    logic              m0_grant;
    logic              m1_grant;
    logic              m_req;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_dout;

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_dout,
        input  m1_req, m1_wr, m1_addr, m1_dout,
        output m0_grant, m1_grant, m_req, m_wr, m_addr, m_dout
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_dout,
        output m1_req, m1_wr, m1_addr, m1_dout,
        input  m0_grant, m1_grant, m_req, m_wr, m_addr, m_dout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master arbiter with registered one-hot grant and a mux forwarding the owner's request to the decoder.
// Define BUS_ARB_TENURE_EN to bound contended ownership to MAX_TENURE cycles.
module bus_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MAX_TENURE = 16
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);
    typedef enum logic {GNT_M0 = 1'b0, GNT_M1 = 1'b1} state_t;

    if (MAX_TENURE < 2) begin : g_bad_tenure
        $error("MAX_TENURE must be at least 2");
    end

    state_t            state;
    logic              m0_grant_q;
    logic              m1_grant_q;
    logic              both_req;
    logic              expire;
    logic              switch_st;
    logic              req_mux;
    logic              wr_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] dout_mux;

    assign both_req = bus.m0_req & bus.m1_req;

`ifdef BUS_ARB_TENURE_EN
    localparam int              TW       = $clog2(MAX_TENURE);
    localparam logic [TW-1:0]   TEN_LAST = TW'(MAX_TENURE - 1);

    logic [TW-1:0] tenure;

    assign expire = both_req && (tenure == TEN_LAST);

    // Counts only uninterrupted contention within one ownership; saturates rather than wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tenure <= '0;
        else if (switch_st || !both_req)
            tenure <= '0;
        else if (tenure != TEN_LAST)
            tenure <= tenure + 1'b1;
    end
`else
    assign expire = 1'b0;
`endif

    // M0 wins ties when it owns the bus; M1 keeps the bus for as long as it asks.
    assign switch_st = (state == GNT_M0) ? ((!bus.m0_req && bus.m1_req) || expire)
                                         : (!bus.m1_req || expire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= GNT_M0;
            m0_grant_q <= 1'b1;
            m1_grant_q <= 1'b0;
        end else if (switch_st) begin
            state      <= (state == GNT_M0) ? GNT_M1 : GNT_M0;
            m0_grant_q <= (state == GNT_M1);
            m1_grant_q <= (state == GNT_M0);
        end
    end

    always_comb begin
        req_mux  = bus.m0_req;
        wr_mux   = bus.m0_wr & bus.m0_req;
        addr_mux = bus.m0_addr;
        dout_mux = bus.m0_dout;
        if (m1_grant_q) begin
            req_mux  = bus.m1_req;
            wr_mux   = bus.m1_wr & bus.m1_req;
            addr_mux = bus.m1_addr;
            dout_mux = bus.m1_dout;
        end
    end

    assign bus.m0_grant = m0_grant_q;
    assign bus.m1_grant = m1_grant_q;
    assign bus.m_req    = req_mux;
    assign bus.m_wr     = wr_mux;
    assign bus.m_addr   = addr_mux;
    assign bus.m_dout   = dout_mux;
endmodule
